// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer.
// Runs one req/ack transaction per EX/MEM load or store, freezes the upstream
// pipeline while it is in flight, and bubbles MEM_WB while stalled.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] readMem_o,
  output logic              stall_o,
  output logic              wb_kill_o,
  output logic              bus_err_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            pending;
  logic            stall;
  logic            timeout_hit;

  assign pending     = mem_read_i | mem_write_i;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

  // Next-state and stall decode
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          stall     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        // An ack arriving on the final timeout cycle still completes the access.
        if (dmem_ack_i)       state_nxt = DONE;
        else if (timeout_hit) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     stall     = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // IDLE stall is combinational on the EX/MEM inputs, so gate it with reset
  // to make the freeze drop the instant reset asserts.
  assign stall_o    = stall & rst_n;
  assign wb_kill_o  = stall_o;
  assign dmem_req_o = (state == ACCESS);
  assign bus_err_o  = (state == ERR);

  // State, request latches, load data and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      readMem_o    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pending) begin
        to_cnt       <= '0;
        dmem_we_o    <= mem_write_i;
        dmem_addr_o  <= addr_i;
        dmem_wdata_o <= wdata_i;
      end
      if (state == ACCESS) begin
        if (dmem_ack_i) begin
          if (!dmem_we_o) readMem_o <= dmem_rdata_i;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus pushes expected transactions,
// a negedge monitor checks each request and the DONE cycle that follows it.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        ack;
  logic [31:0] rdata_in;
  logic [31:0] readMem_o;
  logic        stall_o;
  logic        wb_kill_o;
  logic        bus_err_o;
  logic [15:0] stall_cnt_o;

  dmem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4),
    .TO_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read_i  (mem_read),
    .mem_write_i (mem_write),
    .addr_i      (addr_in),
    .wdata_i     (wdata_in),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i  (ack),
    .dmem_rdata_i(rdata_in),
    .readMem_o   (readMem_o),
    .stall_o     (stall_o),
    .wb_kill_o   (wb_kill_o),
    .bus_err_o   (bus_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t done_exp;
  logic chk_done;
  int   tests;
  int   fails;
  int   exp_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: request fields held against queue head, DONE-cycle result checked
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_done = 1'b0;
    end else begin
      chk("kill_eq_stall", {31'd0, wb_kill_o}, {31'd0, stall_o});
      if (chk_done) begin
        chk("done_readmem", readMem_o, done_exp.rd);
        chk("done_stall", {31'd0, stall_o}, 32'd0);
        chk("done_req", {31'd0, dmem_req_o}, 32'd0);
        chk_done = 1'b0;
      end
      if (dmem_req_o) begin
        if (q.size() == 0) begin
          chk("unexpected_req", {31'd0, dmem_req_o}, 32'd0);
        end else begin
          chk("req_we", {31'd0, dmem_we_o}, {31'd0, q[0].we});
          chk("req_addr", dmem_addr_o, q[0].addr);
          chk("req_wdata", dmem_wdata_o, q[0].wdata);
          chk("req_stall", {31'd0, stall_o}, 32'd1);
          if (ack) begin
            done_exp = q.pop_front();
            chk_done = 1'b1;
          end
        end
      end
    end
  end

  // Issue one access from IDLE; return in IDLE with the EX/MEM inputs cleared
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int waits,
                       input logic [31:0] rdat, input logic [31:0] exp_rd);
    exp_t e;
    mem_read  = rd;
    mem_write = wr;
    addr_in   = a;
    wdata_in  = wd;
    e.we = wr; e.addr = a; e.wdata = wd; e.rd = exp_rd;
    q.push_back(e);
    #1 chk("idle_stall_comb", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
    end
    ack      = 1'b1;
    rdata_in = rdat;
    @(posedge clk); #1;
    ack      = 1'b0;
    rdata_in = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_stall += 2 + waits;
    chk("stall_cnt", {16'd0, stall_cnt_o}, exp_stall);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'd0, dmem_req_o}, 32'd0);
    chk({tag, "_stall"},  {31'd0, stall_o},    32'd0);
    chk({tag, "_kill"},   {31'd0, wb_kill_o},  32'd0);
    chk({tag, "_buserr"}, {31'd0, bus_err_o},  32'd0);
    chk({tag, "_scnt"},   {16'd0, stall_cnt_o}, 32'd0);
    chk({tag, "_rdmem"},  readMem_o,   32'd0);
    chk({tag, "_addr"},   dmem_addr_o, 32'd0);
    chk({tag, "_we"},     {31'd0, dmem_we_o}, 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0; exp_stall = 0; chk_done = 1'b0;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr_in = '0; wdata_in = '0; ack = 1'b0; rdata_in = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero-wait load, 3-wait store (ack on the timeout cycle), back-to-back loads
    do_op(1'b1, 1'b0, 32'h100, 32'h0,        0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 32'h204, 32'h1234_5678, 3, 32'hFFFF_0000, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 32'h300, 32'h0,        0, 32'hA5A5_0001, 32'hA5A5_0001);
    do_op(1'b1, 1'b0, 32'h304, 32'h0,        0, 32'h0BAD_F00D, 32'h0BAD_F00D);
    // Read and write both set behaves as a store
    do_op(1'b1, 1'b1, 32'h308, 32'h55AA_55AA, 1, 32'h1111_1111, 32'h0BAD_F00D);

    // ALU-only stream
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("alu_stall", {31'd0, stall_o},    32'd0);
      chk("alu_req",   {31'd0, dmem_req_o}, 32'd0);
    end
    @(posedge clk); #1;
    chk("alu_scnt", {16'd0, stall_cnt_o}, 32'd14);

    // Load with no ack: ERR after exactly 4 ACCESS cycles
    mem_read = 1'b1; addr_in = 32'h400; wdata_in = 32'h0;
    begin
      exp_t e;
      e.we = 1'b0; e.addr = 32'h400; e.wdata = 32'h0; e.rd = 32'h0;
      q.push_back(e);
    end
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("to_still_access", {31'd0, dmem_req_o}, 32'd1);
    chk("to_no_err_yet",   {31'd0, bus_err_o},  32'd0);
    @(posedge clk); #1;
    chk("err_buserr", {31'd0, bus_err_o},  32'd1);
    chk("err_stall",  {31'd0, stall_o},    32'd1);
    chk("err_req",    {31'd0, dmem_req_o}, 32'd0);
    ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("err_held_buserr", {31'd0, bus_err_o},  32'd1);
    chk("err_held_stall",  {31'd0, stall_o},    32'd1);
    chk("err_held_req",    {31'd0, dmem_req_o}, 32'd0);
    chk("err_held_rdmem",  readMem_o, 32'h0BAD_F00D);
    ack = 1'b0;
    q.delete();

    // Reset out of ERR, then a normal load
    rst_n = 1'b0; mem_read = 1'b0;
    #1 chk_reset_outputs("err_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = 0;
    do_op(1'b1, 1'b0, 32'h600, 32'h0, 0, 32'hCAFE_0001, 32'hCAFE_0001);

    // Reset asserted mid-ACCESS with the load still presented
    mem_read = 1'b1; addr_in = 32'h500;
    begin
      exp_t e;
      e.we = 1'b0; e.addr = 32'h500; e.wdata = 32'h0; e.rd = 32'h0;
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("mid_req_before", {31'd0, dmem_req_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("mid_stall", {31'd0, stall_o},    32'd0);
    chk("mid_kill",  {31'd0, wb_kill_o},  32'd0);
    chk("mid_rdmem", readMem_o, 32'd0);
    q.delete();
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_reset_idle");
    exp_stall = 0;
    do_op(1'b1, 1'b0, 32'h700, 32'h0, 2, 32'h7777_0007, 32'h7777_0007);

    repeat (2) @(posedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
